axi_rd_arb: RTL and testbench

AXI_RD_ARB -- requirements
Module: axi_rd_arb

---
 rtl/axi_rd_arb.sv | 175 +++++++++++++++++
 tb/tb_axi_rd_arb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arb.sv
// Two-master to one-slave AXI read arbiter with a single outstanding transaction.
// Grant is decided in IDLE, the AR beat is forwarded in ADDR and R beats are routed back in DATA.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 16
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module axi_rd_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [`AXI_ID_WIDTH-1:0]    m0_arid,
  input  logic [`AXI_ADDR_WIDTH-1:0]  m0_araddr,
  input  logic [`AXI_LEN_WIDTH-1:0]   m0_arlen,
  input  logic [`AXI_SIZE_WIDTH-1:0]  m0_arsize,
  input  logic [`AXI_BURST_WIDTH-1:0] m0_arburst,
  input  logic                        m0_arvalid,
  output logic                        m0_arready,
  input  logic [`AXI_ID_WIDTH-1:0]    m1_arid,
  input  logic [`AXI_ADDR_WIDTH-1:0]  m1_araddr,
  input  logic [`AXI_LEN_WIDTH-1:0]   m1_arlen,
  input  logic [`AXI_SIZE_WIDTH-1:0]  m1_arsize,
  input  logic [`AXI_BURST_WIDTH-1:0] m1_arburst,
  input  logic                        m1_arvalid,
  output logic                        m1_arready,
  output logic [`AXI_DATA_WIDTH-1:0]  m0_rdata,
  output logic [`AXI_DATA_WIDTH-1:0]  m1_rdata,
  output logic [`AXI_RESP_WIDTH-1:0]  m0_rresp,
  output logic [`AXI_RESP_WIDTH-1:0]  m1_rresp,
  output logic                        m0_rlast,
  output logic                        m1_rlast,
  output logic                        m0_rvalid,
  output logic                        m1_rvalid,
  input  logic                        m0_rready,
  input  logic                        m1_rready,
  output logic [`AXI_ID_WIDTH-1:0]    s_arid,
  output logic [`AXI_ADDR_WIDTH-1:0]  s_araddr,
  output logic [`AXI_LEN_WIDTH-1:0]   s_arlen,
  output logic [`AXI_SIZE_WIDTH-1:0]  s_arsize,
  output logic [`AXI_BURST_WIDTH-1:0] s_arburst,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  input  logic [`AXI_DATA_WIDTH-1:0]  s_rdata,
  input  logic [`AXI_RESP_WIDTH-1:0]  s_rresp,
  input  logic                        s_rlast,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  output logic                        grant,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                     state_q, state_d;
  logic                       grant_q, grant_d;
  logic                       last_q, last_d;
  logic [`AXI_LEN_WIDTH-1:0]  beat_q, beat_d;
  logic                       r_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign r_hs = s_rvalid & (grant_q ? m1_rready : m0_rready);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beat_d     = beat_q;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    m0_rresp   = '0;
    m1_rresp   = '0;
    m0_rlast   = 1'b0;
    m1_rlast   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    s_arid     = '0;
    s_araddr   = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          // Conflict: round-robin favours whoever did not win last time.
          if (m0_arvalid && m1_arvalid) grant_d = RR_EN ? ~last_q : 1'b0;
          else                          grant_d = m1_arvalid;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // Held even if the master withdraws arvalid; no re-arbitration here.
        s_arvalid = 1'b1;
        if (grant_q) begin
          s_arid     = m1_arid;
          s_araddr   = m1_araddr;
          s_arlen    = m1_arlen;
          s_arsize   = m1_arsize;
          s_arburst  = m1_arburst;
          m1_arready = s_arready;
        end else begin
          s_arid     = m0_arid;
          s_araddr   = m0_araddr;
          s_arlen    = m0_arlen;
          s_arsize   = m0_arsize;
          s_arburst  = m0_arburst;
          m0_arready = s_arready;
        end
        if (s_arready) begin
          last_d  = grant_q;
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        m0_rdata = s_rdata;
        m1_rdata = s_rdata;
        m0_rresp = s_rresp;
        m1_rresp = s_rresp;
        m0_rlast = s_rlast;
        m1_rlast = s_rlast;
        if (grant_q) begin
          m1_rvalid = s_rvalid;
          s_rready  = m1_rready;
        end else begin
          m0_rvalid = s_rvalid;
          s_rready  = m0_rready;
        end
        if (r_hs) begin
          beat_d = beat_q + 1'b1;
          if (s_rlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb: bench acts as both masters and the shared slave,
// with AR and R expectations queued when driven and checked when the DUT presents them.
`timescale 1ns/1ps
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 16
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module tb_axi_rd_arb;
  localparam int IW = `AXI_ID_WIDTH;
  localparam int AW = `AXI_ADDR_WIDTH;
  localparam int LW = `AXI_LEN_WIDTH;
  localparam int SW = `AXI_SIZE_WIDTH;
  localparam int BW = `AXI_BURST_WIDTH;
  localparam int DW = `AXI_DATA_WIDTH;
  localparam int RW = `AXI_RESP_WIDTH;
  localparam logic [IW-1:0] ID0 = IW'(3);
  localparam logic [IW-1:0] ID1 = IW'(5);

  logic clk = 1'b0, rst = 1'b1, rst_f = 1'b1;
  logic [IW-1:0] m0_arid = ID0, m1_arid = ID1;
  logic [AW-1:0] m0_araddr = '0, m1_araddr = '0;
  logic [LW-1:0] m0_arlen = '0, m1_arlen = '0;
  logic [SW-1:0] m0_arsize = SW'(2), m1_arsize = SW'(2);
  logic [BW-1:0] m0_arburst = BW'(1), m1_arburst = BW'(1);
  logic m0_arvalid = 1'b0, m1_arvalid = 1'b0, m0_rready = 1'b1, m1_rready = 1'b1;
  logic s_arready = 1'b1;
  logic [DW-1:0] s_rdata = '0;
  logic [RW-1:0] s_rresp = '0;
  logic s_rlast = 1'b0, s_rvalid = 1'b0;

  logic m0_arready, m1_arready, m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [RW-1:0] m0_rresp, m1_rresp;
  logic [IW-1:0] s_arid;
  logic [AW-1:0] s_araddr;
  logic [LW-1:0] s_arlen;
  logic [SW-1:0] s_arsize;
  logic [BW-1:0] s_arburst;
  logic s_arvalid, s_rready, grant, busy;

  logic f_m0_arready, f_m1_arready, f_m0_rlast, f_m1_rlast, f_m0_rvalid, f_m1_rvalid;
  logic [DW-1:0] f_m0_rdata, f_m1_rdata;
  logic [RW-1:0] f_m0_rresp, f_m1_rresp;
  logic [IW-1:0] f_s_arid;
  logic [AW-1:0] f_s_araddr;
  logic [LW-1:0] f_s_arlen;
  logic [SW-1:0] f_s_arsize;
  logic [BW-1:0] f_s_arburst;
  logic f_s_arvalid, f_s_rready, f_grant, f_busy;

  always #5 clk = ~clk;

  axi_rd_arb #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_rresp(m0_rresp), .m1_rresp(m1_rresp),
    .m0_rlast(m0_rlast), .m1_rlast(m1_rlast), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rready(m0_rready), .m1_rready(m1_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .grant(grant), .busy(busy)
  );

  axi_rd_arb #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst_f),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(f_m0_arready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(f_m1_arready),
    .m0_rdata(f_m0_rdata), .m1_rdata(f_m1_rdata), .m0_rresp(f_m0_rresp), .m1_rresp(f_m1_rresp),
    .m0_rlast(f_m0_rlast), .m1_rlast(f_m1_rlast), .m0_rvalid(f_m0_rvalid), .m1_rvalid(f_m1_rvalid),
    .m0_rready(m0_rready), .m1_rready(m1_rready),
    .s_arid(f_s_arid), .s_araddr(f_s_araddr), .s_arlen(f_s_arlen), .s_arsize(f_s_arsize),
    .s_arburst(f_s_arburst), .s_arvalid(f_s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(f_s_rready), .grant(f_grant), .busy(f_busy)
  );

  typedef struct { logic g; logic [AW-1:0] addr; logic [LW-1:0] len; } ar_exp_t;
  typedef struct { logic [DW-1:0] data; logic [RW-1:0] resp; logic last; } r_exp_t;
  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  int n_chk = 0, n_fail = 0;
  bit fp_chk = 1'b0;
  logic cur_g = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [LW-1:0] cur_len = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic m, input logic [AW-1:0] a, input logic [LW-1:0] l);
    if (m) begin m1_araddr = a; m1_arlen = l; m1_arvalid = 1'b1; end
    else   begin m0_araddr = a; m0_arlen = l; m0_arvalid = 1'b1; end
  endtask

  task automatic expect_ar(input logic g, input logic [AW-1:0] a, input logic [LW-1:0] l);
    ar_exp_t e;
    e.g = g; e.addr = a; e.len = l;
    ar_q.push_back(e);
  endtask

  // Waits (bounded) for the slave AR request, checks it, then lets the handshake happen.
  task automatic ar_phase(input bit drop);
    ar_exp_t e;
    int lat = 0;
    do begin @(negedge clk); #1; lat++; end while (!s_arvalid && lat < 8);
    chk("ar_latency", lat, 1);
    if (ar_q.size() == 0) begin
      n_chk++; n_fail++;
      $error("FAIL ar_queue: observed=empty expected=entry");
      return;
    end
    e = ar_q.pop_front();
    $display("AR  t=%0t grant=%0d addr=%0h len=%0d (exp g=%0d addr=%0h len=%0d)",
             $time, grant, s_araddr, s_arlen, e.g, e.addr, e.len);
    chk("grant", grant, e.g);
    chk("busy_addr", busy, 1);
    chk("s_araddr", s_araddr, e.addr);
    chk("s_arlen", s_arlen, e.len);
    chk("s_arid", s_arid, e.g ? ID1 : ID0);
    chk("arready_win", e.g ? m1_arready : m0_arready, 1);
    chk("arready_lose", e.g ? m0_arready : m1_arready, 0);
    if (fp_chk) begin
      chk("fp_grant", f_grant, 0);
      chk("fp_araddr", f_s_araddr, m0_araddr);
    end
    @(negedge clk);
    if (drop) begin
      if (e.g) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
    end
    #1;
    chk("data_arvalid", s_arvalid, 0);
    chk("data_arready", {m0_arready, m1_arready}, 0);
    cur_g = e.g; cur_addr = e.addr; cur_len = e.len;
  endtask

  // Bench slave: data = addr + beat, DECERR for the unmapped hole 0x4-0x7.
  task automatic r_phase(input bit toggle, input int nb);
    r_exp_t e;
    logic [RW-1:0] resp;
    logic rdy;
    resp = ((cur_addr >> 2) == AW'(1)) ? RW'(3) : RW'(0);
    for (int i = 0; i < nb; i++) begin
      s_rvalid = 1'b1;
      s_rdata  = DW'(cur_addr) + DW'(i);
      s_rresp  = resp;
      s_rlast  = (i == int'(cur_len));
      e.data = s_rdata; e.resp = resp; e.last = s_rlast;
      r_q.push_back(e);
      for (int w = 0; w < 8; w++) begin
        if (toggle) begin
          if (cur_g) m1_rready = ~m1_rready; else m0_rready = ~m0_rready;
        end
        #1;
        rdy = cur_g ? m1_rready : m0_rready;
        chk("rvalid_win", cur_g ? m1_rvalid : m0_rvalid, 1);
        chk("rvalid_lose", cur_g ? m0_rvalid : m1_rvalid, 0);
        chk("s_rready", s_rready, rdy);
        if (rdy) begin
          e = r_q.pop_front();
          $display("R   t=%0t m%0d data=%0h resp=%0d last=%0d (exp data=%0h resp=%0d last=%0d)",
                   $time, cur_g, cur_g ? m1_rdata : m0_rdata, cur_g ? m1_rresp : m0_rresp,
                   cur_g ? m1_rlast : m0_rlast, e.data, e.resp, e.last);
          chk("rdata", cur_g ? m1_rdata : m0_rdata, e.data);
          chk("rresp", cur_g ? m1_rresp : m0_rresp, e.resp);
          chk("rlast", cur_g ? m1_rlast : m0_rlast, e.last);
          @(negedge clk);
          break;
        end
        @(negedge clk);
      end
    end
    if (nb == int'(cur_len) + 1) begin
      s_rvalid = 1'b0; s_rlast = 1'b0;
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_rvalid", {m0_rvalid, m1_rvalid}, 0);
      chk("idle_rready", s_rready, 0);
    end
  endtask

  task automatic pulse_reset(input bit with_fp);
    @(negedge clk);
    rst = 1'b1;
    if (with_fp) rst_f = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (with_fp) rst_f = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("reset_outputs", {busy, grant, s_arvalid, m0_arready, m1_arready, s_rready, m0_rvalid, m1_rvalid}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_busy0", busy, 0);

    // Single m0 request, 4 beats
    drive_req(1'b0, AW'(0), LW'(3));
    expect_ar(1'b0, AW'(0), LW'(3));
    chk("idle_s_arvalid", s_arvalid, 0);
    ar_phase(1'b1);
    r_phase(1'b0, 4);

    // Round-robin with both masters requesting
    pulse_reset(1'b0);
    drive_req(1'b0, AW'('h10), LW'(1));
    drive_req(1'b1, AW'('h20), LW'(0));
    expect_ar(1'b0, AW'('h10), LW'(1));
    expect_ar(1'b1, AW'('h20), LW'(0));
    expect_ar(1'b0, AW'('h10), LW'(1));
    repeat (3) begin ar_phase(1'b0); r_phase(1'b0, int'(cur_len) + 1); end
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;

    // Fixed priority instance alongside, both masters requesting continuously
    pulse_reset(1'b1);
    fp_chk = 1'b1;
    drive_req(1'b0, AW'('h40), LW'(0));
    drive_req(1'b1, AW'('h50), LW'(0));
    expect_ar(1'b0, AW'('h40), LW'(0));
    expect_ar(1'b1, AW'('h50), LW'(0));
    expect_ar(1'b0, AW'('h40), LW'(0));
    repeat (3) begin ar_phase(1'b0); r_phase(1'b0, 1); end
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    fp_chk = 1'b0;
    rst_f = 1'b1;

    // Decode miss
    drive_req(1'b0, AW'('h4), LW'(0));
    expect_ar(1'b0, AW'('h4), LW'(0));
    ar_phase(1'b1);
    r_phase(1'b0, 1);

    // m1 with toggling rready
    m1_rready = 1'b1;
    drive_req(1'b1, AW'('h100), LW'(3));
    expect_ar(1'b1, AW'('h100), LW'(3));
    ar_phase(1'b1);
    r_phase(1'b1, 4);
    m1_rready = 1'b1;

    // Reset in the middle of DATA after two beats
    drive_req(1'b0, AW'('h200), LW'(3));
    expect_ar(1'b0, AW'('h200), LW'(3));
    ar_phase(1'b1);
    r_phase(1'b0, 2);
    s_rvalid = 1'b1; s_rdata = DW'('h202); s_rlast = 1'b0;
    #1;
    chk("abort_pre_rvalid", m0_rvalid, 1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {busy, grant, s_arvalid, s_rready, m0_rvalid, m1_rvalid, m0_arready, m1_arready}, 0);
    chk("abort_rdata", m0_rdata, 0);
    @(negedge clk);
    rst = 1'b0; s_rvalid = 1'b0;
    drive_req(1'b0, AW'('h300), LW'(0));
    expect_ar(1'b0, AW'('h300), LW'(0));
    ar_phase(1'b1);
    r_phase(1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
